flash_word_reader: RTL and testbench

- Upstream stage of the boot loader's flash-to-SRAM copy engine.
- Serves the loader's word-read handshake (flashCs / flashAddr / flashReady / flashData).
- Drives an external 16-bit asynchronous parallel NOR flash with two half-word reads per 32-bit word, little-endian.
- Paces each flash read by a programmable wait-state count and enforces a power-up delay before first use.

---
 rtl/flash_word_reader_pkg.sv | 26 ++
 rtl/flash_word_reader.sv | 131 +++++++++++++
 tb/tb_flash_word_reader.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/flash_word_reader_pkg.sv
// Shared definitions for the boot loader copy engine: reader/writer state
// encodings and default timing constants.
package flash_word_reader_pkg;

  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_RD_LO = 2'd2;
  localparam logic [1:0] ST_RD_HI = 2'd3;

  typedef enum logic [1:0] {
    INIT  = ST_INIT,
    IDLE  = ST_IDLE,
    RD_LO = ST_RD_LO,
    RD_HI = ST_RD_HI
  } stateT;

  localparam int DEF_FLASH_AW     = 23;
  localparam int DEF_WAIT_CYCLES  = 8;
  localparam int DEF_PWRUP_CYCLES = 1000;

  // Down-counter reload value for a phase lasting 'cycles' clocks
  function automatic logic [15:0] cycleLoad(input int cycles);
    return 16'(cycles - 1);
  endfunction

endpackage

// File: rtl/flash_word_reader.sv
// Word-read front end for a 16-bit async NOR flash: two wait-stated half-word
// reads per 32-bit word (little-endian), gated by a power-up delay.
module flash_word_reader
  import flash_word_reader_pkg::*;
#(
  parameter int FLASH_AW     = DEF_FLASH_AW,
  parameter int WAIT_CYCLES  = DEF_WAIT_CYCLES,
  parameter int PWRUP_CYCLES = DEF_PWRUP_CYCLES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flashCs,
  input  logic [24:0]         flashAddr,
  output logic                flashReady,
  output logic [31:0]         flashData,
  output logic [FLASH_AW-1:0] flash_a,
  input  logic [15:0]         flash_d,
  output logic                flash_ce_n,
  output logic                flash_oe_n,
  output logic                flash_we_n,
  output logic                flash_rst_n
);

  localparam logic [15:0] WAIT_LOAD  = cycleLoad(WAIT_CYCLES);
  localparam logic [15:0] PWRUP_LOAD = cycleLoad(PWRUP_CYCLES);

  stateT                state, stateNext;
  logic [15:0]          count, countNext;
  logic                 csQ;
  logic                 busN, busNNext;
  logic                 readyNext;
  logic                 devRstNNext;
  logic [31:0]          dataNext;
  logic [FLASH_AW-1:0]  aNext;
  logic [15:0]          loHalf, loHalfNext;
  logic                 unusedAddrHi;

  // Word index bits beyond the device size are deliberately dropped
  assign unusedAddrHi = &{1'b0, flashAddr[24:FLASH_AW-1]};

  // ce_n and oe_n always move together; the device is never written
  assign flash_ce_n = busN;
  assign flash_oe_n = busN;
  assign flash_we_n = 1'b1;

  // Next-state, shared counter and output-register logic
  always_comb begin
    stateNext   = state;
    countNext   = count;
    busNNext    = busN;
    readyNext   = flashReady;
    devRstNNext = flash_rst_n;
    dataNext    = flashData;
    aNext       = flash_a;
    loHalfNext  = loHalf;
    case (state)
      INIT: begin
        if (count == 16'd0) begin
          devRstNNext = 1'b1;
          readyNext   = 1'b1;
          stateNext   = IDLE;
        end else begin
          countNext = count - 16'd1;
        end
      end
      IDLE: begin
        busNNext = 1'b1;
        // Only a fresh rising edge of flashCs starts a read
        if (flashCs && !csQ) begin
          readyNext = 1'b0;
          aNext     = {flashAddr[FLASH_AW-2:0], 1'b0};
          busNNext  = 1'b0;
          countNext = WAIT_LOAD;
          stateNext = RD_LO;
        end else begin
          stateNext = IDLE;
        end
      end
      RD_LO: begin
        if (count == 16'd0) begin
          loHalfNext = flash_d;
          aNext[0]   = 1'b1;
          countNext  = WAIT_LOAD;
          stateNext  = RD_HI;
        end else begin
          countNext = count - 16'd1;
        end
      end
      RD_HI: begin
        if (count == 16'd0) begin
          dataNext  = {flash_d, loHalf};
          readyNext = 1'b1;
          busNNext  = 1'b1;
          stateNext = IDLE;
        end else begin
          countNext = count - 16'd1;
        end
      end
      default: begin
        busNNext  = 1'b1;
        stateNext = IDLE;
      end
    endcase
  end

  // State, counter and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= INIT;
      count       <= PWRUP_LOAD;
      csQ         <= 1'b0;
      busN        <= 1'b1;
      flashReady  <= 1'b0;
      flash_rst_n <= 1'b0;
      flashData   <= 32'd0;
      flash_a     <= '0;
      loHalf      <= 16'd0;
    end else begin
      state       <= stateNext;
      count       <= countNext;
      csQ         <= flashCs;
      busN        <= busNNext;
      flashReady  <= readyNext;
      flash_rst_n <= devRstNNext;
      flashData   <= dataNext;
      flash_a     <= aNext;
      loHalf      <= loHalfNext;
    end
  end

endmodule

// File: tb/tb_flash_word_reader.sv
// Self-checking bench for flash_word_reader against a behavioural NOR flash
// model and word-level expectations.
module tb_flash_word_reader;

  localparam int AW = 23;
  localparam int W  = 4;
  localparam int P  = 20;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flashCs;
  logic [24:0]   flashAddr;
  logic          flashReady;
  logic [31:0]   flashData;
  logic [AW-1:0] flash_a;
  logic [15:0]   flashD;
  logic          flash_ce_n, flash_oe_n, flash_we_n, flash_rst_n;

  flash_word_reader #(.FLASH_AW(AW), .WAIT_CYCLES(W), .PWRUP_CYCLES(P)) dut (
    .clk(clk), .rst_n(rst_n), .flashCs(flashCs), .flashAddr(flashAddr),
    .flashReady(flashReady), .flashData(flashData), .flash_a(flash_a),
    .flash_d(flashD), .flash_ce_n(flash_ce_n), .flash_oe_n(flash_oe_n),
    .flash_we_n(flash_we_n), .flash_rst_n(flash_rst_n)
  );

  always #5 clk = ~clk;

  // Flash contents: explicit entries, otherwise a seeded address hash
  logic [15:0] mem [logic [AW-1:0]];
  logic [15:0] seed16;
  int          memGen = 0;

  function automatic logic [15:0] halfAt(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return 16'(a ^ (a >> 7)) ^ seed16;
  endfunction

  function automatic logic [31:0] expWord(input logic [24:0] addr);
    logic [AW-1:0] a;
    a = AW'(addr << 1);
    return {halfAt(a | AW'(1)), halfAt(a)};
  endfunction

  always @(flash_a or memGen) flashD = halfAt(flash_a);

  int txCount = 0;
  int readyRises = 0;
  logic badAddr = 1'b0;
  always @(negedge flash_ce_n) txCount++;
  always @(posedge flashReady) readyRises++;
  always @(posedge clk)
    if (!flash_ce_n && (flash_a == AW'(18) || flash_a == AW'(19))) badAddr = 1'b1;

  int nChecks = 0;
  int nPass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic waitReady(output int n);
    n = 0;
    while (!flashReady && n < 5000) begin
      step();
      n++;
    end
  endtask

  // One request; returns edges from request to ready and whether flash_a
  // followed the even/odd address schedule with the bus enabled
  task automatic doRead(input logic [24:0] addr, input int hold,
                        output int lat, output logic addrOk);
    logic [AW-1:0] a;
    a = AW'(addr << 1);
    flashCs = 1'b1;
    flashAddr = addr;
    lat = -1;
    addrOk = 1'b1;
    for (int k = 0; k < 200; k++) begin
      step();
      if (k + 1 >= hold) flashCs = 1'b0;
      flashAddr = 25'($urandom);
      if (flashReady) begin
        lat = k;
        break;
      end
      if (flash_a !== ((k < W) ? a : (a | AW'(1)))) addrOk = 1'b0;
      if (flash_ce_n !== 1'b0 || flash_oe_n !== 1'b0) addrOk = 1'b0;
    end
  endtask

  task automatic readAndCheck(input string tag, input logic [24:0] addr, input int hold);
    int lat;
    logic addrOk;
    int t0;
    t0 = txCount;
    doRead(addr, hold, lat, addrOk);
    check({tag, " latency"}, 32'(lat), 32'(2 * W));
    check({tag, " addr"}, {31'd0, addrOk}, 32'd1);
    check({tag, " data"}, flashData, expWord(addr));
    check({tag, " bus idle"}, {30'd0, flash_ce_n, flash_oe_n}, 32'd3);
    check({tag, " tx count"}, 32'(txCount - t0), 32'd1);
  endtask

  initial begin
    int n, r0, t0;
    logic rstOk, ceOk;
    logic [24:0] addr;
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, r0, t0;
    logic rstOk, ceOk, holdOk;
    logic [24:0] addr;
    seed16 = 16'($urandom);
    memGen++;
    rst_n = 1'b0;
    flashCs = 1'b0;
    flashAddr = 25'd0;
    step();
    step();

    // Reset values
    check("rst ready", {31'd0, flashReady}, 32'd0);
    check("rst data", flashData, 32'd0);
    check("rst addr", 32'(flash_a), 32'd0);
    check("rst bus", {29'd0, flash_ce_n, flash_oe_n, flash_we_n}, 32'd7);
    check("rst devrst", {31'd0, flash_rst_n}, 32'd0);

    // Power-up delay; flashCs raised mid-INIT must not start a read
    rst_n = 1'b1;
    n = 0;
    rstOk = 1'b1;
    ceOk = 1'b1;
    while (!flashReady && n < 100) begin
      step();
      n++;
      if (n == 5) flashCs = 1'b1;
      if (!flashReady && flash_rst_n !== 1'b0) rstOk = 1'b0;
      if (flash_ce_n !== 1'b1) ceOk = 1'b0;
    end
    check("pwrup cycles", 32'(n), 32'(P));
    check("pwrup devrst low", {31'd0, rstOk}, 32'd1);
    check("pwrup devrst high", {31'd0, flash_rst_n}, 32'd1);
    t0 = txCount;
    for (int i = 0; i < 6; i++) begin
      step();
      if (flash_ce_n !== 1'b1 || flashReady !== 1'b1) ceOk = 1'b0;
    end
    check("pwrup cs ignored", {31'd0, ceOk}, 32'd1);
    check("pwrup no tx", 32'(txCount - t0), 32'd0);
    flashCs = 1'b0;
    step();

    // Single read of word 3
    mem[AW'(6)] = 16'hBEEF;
    mem[AW'(7)] = 16'hDEAD;
    memGen++;
    readAndCheck("single", 25'd3, 1);
    check("single word", flashData, 32'hDEADBEEF);

    // Copy-engine pattern over words 0..3
    for (int i = 0; i < 8; i++) mem[AW'(i)] = 16'($urandom);
    memGen++;
    for (int i = 0; i < 4; i++) begin
      step();
      readAndCheck($sformatf("copy%0d", i), 25'(i), 2);
    end

    // Second rising edge during RD_LO is ignored
    step();
    r0 = readyRises;
    t0 = txCount;
    badAddr = 1'b0;
    flashCs = 1'b1;
    flashAddr = 25'd2;
    step();
    flashCs = 1'b0;
    step();
    step();
    flashCs = 1'b1;
    flashAddr = 25'd9;
    step();
    step();
    flashCs = 1'b0;
    waitReady(n);
    repeat (3 * W) step();
    check("busy ready rises", 32'(readyRises - r0), 32'd1);
    check("busy tx count", 32'(txCount - t0), 32'd1);
    check("busy no addr 9", {31'd0, badAddr}, 32'd0);
    check("busy data", flashData, expWord(25'd2));

    // Reset asserted during RD_HI
    flashCs = 1'b1;
    flashAddr = 25'd5;
    step();
    flashCs = 1'b0;
    repeat (W + 1) step();
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst bus", {30'd0, flash_ce_n, flash_oe_n}, 32'd3);
    check("midrst ready", {31'd0, flashReady}, 32'd0);
    check("midrst data", flashData, 32'd0);
    check("midrst devrst", {31'd0, flash_rst_n}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    waitReady(n);
    check("midrst init delay", 32'(n), 32'(P));
    check("midrst data held", flashData, 32'd0);

    // Randomized reads with random hold times
    for (int i = 0; i < 6; i++) begin
      step();
      addr = 25'($urandom);
      readAndCheck($sformatf("rand%0d", i), addr, int'($urandom_range(3, 1)));
    end

    // Top-of-device word: upper index bits truncated
    mem[AW'(23'h7FFFFE)] = 16'($urandom);
    mem[AW'(23'h7FFFFF)] = 16'($urandom);
    memGen++;
    step();
    readAndCheck("trunc", 25'h1FFFFFF, 1);
    check("trunc word", flashData, {mem[AW'(23'h7FFFFF)], mem[AW'(23'h7FFFFE)]});

    // flashCs held high across completion starts nothing new
    step();
    readAndCheck("hold", 25'd1, 40);
    t0 = txCount;
    holdOk = 1'b1;
    repeat (2 * W + 2) begin
      step();
      if (flashReady !== 1'b1 || flash_ce_n !== 1'b1) holdOk = 1'b0;
    end
    check("hold no rerun", {31'd0, holdOk}, 32'd1);
    check("hold tx count", 32'(txCount - t0), 32'd0);
    flashCs = 1'b0;
    step();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
